// File: rtl/add_seq_pkg.sv
// Shared definitions for the add_sequencer block.
//   SLICE_W : width of one adder slice handled per RUN cycle
//   state_t : sequencer FSM encoding (also exported as a debug output)
package add_seq_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_sequencer_cla8.sv
// 8-bit carry-lookahead adder slice.
// Ports:
//   i_a, i_b : 8-bit operands
//   i_c0     : carry into bit 0
//   o_s      : 8-bit sum
//   o_g, o_p : group generate / propagate; the slice carry-out is
//              o_g | (o_p & i_c0) and is formed by the caller.
module add_sequencer_cla8
  import add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_c0,
  output logic [SLICE_W-1:0] o_s,
  output logic               o_g,
  output logic               o_p
);

  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry comes from the prefix (G, P) of the bits below it, so every
  // carry is a function of the bit-level g/p terms and i_c0 only.
  always_comb begin
    logic v_gg;
    logic v_pp;
    v_gg   = 1'b0;
    v_pp   = 1'b1;
    w_c    = '0;
    w_c[0] = i_c0;
    for (int i = 0; i < SLICE_W; i++) begin
      v_gg       = w_g[i] | (w_p[i] & v_gg);
      v_pp       = v_pp & w_p[i];
      w_c[i + 1] = v_gg | (v_pp & i_c0);
    end
    o_g = v_gg;
    o_p = v_pp;
  end

  assign o_s = w_p ^ w_c[SLICE_W-1:0];

endmodule

// File: rtl/add_sequencer.sv
// Multi-cycle adder/subtractor that time-shares one 8-bit CLA slice.
// Ports:
//   clock, reset_n        : rising-edge clock, async active-low reset
//   start, sub, abort     : request (taken only when ready), 1 = A-B, cancel RUN
//   data_operandA/B       : W-bit operands, latched with start
//   ready                 : high only in IDLE
//   done                  : one-cycle pulse, result/carry_out/overflow valid
//   result, carry_out,
//   overflow              : registered outputs, held until the next DONE
//   dbg_state             : current FSM state
// Handshake: an operation is accepted on a rising edge where ready=1 and
// start=1; done pulses exactly one cycle, SLICES+1 edges after acceptance.
module add_sequencer
  import add_seq_pkg::*;
#(
  parameter int SLICES = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      sub,
  input  logic                      abort,
  input  logic [SLICE_W*SLICES-1:0] data_operandA,
  input  logic [SLICE_W*SLICES-1:0] data_operandB,
  output logic                      ready,
  output logic                      done,
  output logic [SLICE_W*SLICES-1:0] result,
  output logic                      carry_out,
  output logic                      overflow,
  output state_t                    dbg_state
);

  localparam int W     = SLICE_W * SLICES;
  localparam int CNT_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_carry;
  logic [W-1:0]       r_work;
  logic [W-1:0]       r_result;
  logic               r_cout;
  logic               r_ovf;

  int                 w_base;
  logic [SLICE_W-1:0] w_s;
  logic               w_g;
  logic               w_p;
  logic               w_slice_cout;
  logic [W-1:0]       w_sum;
  logic               w_last;
  logic               w_ovf;

  assign w_base = int'(r_cnt) * SLICE_W;
  assign w_last = (r_cnt == LAST);

  add_sequencer_cla8 u_cla8 (
    .i_a  (r_a[w_base +: SLICE_W]),
    .i_b  (r_b[w_base +: SLICE_W]),
    .i_c0 (r_carry),
    .o_s  (w_s),
    .o_g  (w_g),
    .o_p  (w_p)
  );

  assign w_slice_cout = w_g | (w_p & r_carry);

  // Working register with the current slice merged in; on the last slice
  // this is the complete sum.
  always_comb begin
    w_sum = r_work;
    w_sum[w_base +: SLICE_W] = w_s;
  end

  // r_b already holds ~B for subtraction, so one rule covers both modes.
  assign w_ovf = (r_a[W-1] == r_b[W-1]) & (w_sum[W-1] != r_a[W-1]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_work   <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= data_operandA;
            r_b     <= sub ? ~data_operandB : data_operandB;
            r_carry <= sub;
            r_work  <= '0;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_cnt <= '0;
          end else begin
            r_work  <= w_sum;
            r_carry <= w_slice_cout;
            if (w_last) begin
              r_cnt    <= '0;
              r_result <= w_sum;
              r_cout   <= w_slice_cout;
              r_ovf    <= w_ovf;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort)       w_state_nxt = ST_IDLE;
        else if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign result    = r_result;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: doc/add_sequencer.md
ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 SHALL have parameter SLICES, default 4: number of 8-bit slices; operand width W = 8*SLICES.
REQ-002 SHALL have port clock  in  1  rising-edge system clock.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  in  1  request a new operation; sampled only while ready=1.
REQ-005 SHALL have port sub  in  1  0 = A+B, 1 = A-B; latched with start.
REQ-006 SHALL have port abort  in  1  cancel an operation in progress.
REQ-007 SHALL have port data_operandA  in  W  operand A; latched with start.
REQ-008 SHALL have port data_operandB  in  W  operand B; latched with start.
REQ-009 SHALL have port ready  out  1  high only in IDLE.
REQ-010 SHALL have port done  out  1  one-cycle pulse: result, carry_out and overflow are valid.
REQ-011 SHALL have port result  out  W  registered sum/difference.
REQ-012 SHALL have port carry_out  out  1  carry out of bit W-1.
REQ-013 SHALL have port overflow  out  1  signed two's-complement overflow.

Function
REQ-014 SHALL use one CLA8 instance, time-shared across slices:
- CLA8 slice carry-out = G | (P & C0).
REQ-015 SHALL implement states IDLE, RUN and DONE, plus a slice counter 0..SLICES-1.
REQ-016 IDLE with start=1 SHALL, at the edge:
- latch A, B' = sub ? ~B : B, and carry = sub;
- clear the working register;
- set counter to 0;
- go to RUN.
REQ-017 Each RUN cycle SHALL:
- drive CLA8 with A[8i+7:8i], B'[8i+7:8i] and carry, where i = counter;
- at the edge, write S into working[8i+7:8i];
- replace carry with the slice carry-out;
- increment counter.
REQ-018 At the RUN edge with counter=SLICES-1, the block SHALL:
- load result from the working register with the final byte merged in;
- load carry_out from the final carry;
- load overflow = (A[W-1]==B'[W-1]) & (sum[W-1]!=A[W-1]);
- go to DONE.
REQ-019 done SHALL equal 1 exactly while in DONE, and DONE SHALL always return to IDLE on the next edge.
REQ-020 Latency SHALL be SLICES+1 edges from the start-sampling edge to the return of ready: done is high during the cycle following edge k+SLICES.
REQ-021 result, carry_out and overflow SHALL hold their values until the next DONE entry.
REQ-022 start SHALL be ignored outside IDLE; no queuing.
REQ-023 abort=1 in RUN SHALL return the block to IDLE at the next edge:
- no done;
- result, carry_out and overflow unchanged.
REQ-024 abort SHALL be ignored in IDLE and DONE; start and abort both high in IDLE SHALL start the operation.
REQ-025 Operand inputs changing after the start edge SHALL NOT affect the operation in progress.

Reset
REQ-026 reset_n=0 SHALL immediately force:
- state IDLE and counter 0;
- ready=1 and done=0;
- result=0, carry_out=0, overflow=0;
- working register, carry and latched operands cleared.
REQ-027 Reset asserted mid-RUN SHALL discard the operation with no done pulse.
REQ-028 The first start after reset_n deasserts SHALL be accepted on the first rising edge.

Structure
REQ-029 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the slice width constant 8 SHALL live in shared package add_seq_pkg.
REQ-030 The existing CLA8 SHALL be the only sub-module; no other adder logic beyond the carry-out and overflow equations.

Verification
REQ-031 Reset scenario: assert reset_n=0 mid-RUN -> immediately ready=1, done=0, result=0x00000000, overflow=0, carry_out=0.
REQ-032 Overflow scenario: add 0x7FFFFFFF + 0x00000001 with start at edge k:
- done high only in the cycle after edge k+4;
- result=0x80000000, overflow=1, carry_out=0.
REQ-033 Carry-chain scenario: add 0x80808080 + 0x80808080 -> result=0x01010100, carry_out=1, overflow=1.
REQ-034 Subtract scenario: sub 0x00000000 - 0x00000001 -> result=0xFFFFFFFF, carry_out=0, overflow=0; sub 0x00000005 - 0x00000003 -> result=0x00000002, carry_out=1.
REQ-035 Abort scenario: abort on the 2nd RUN cycle -> no done pulse, result retains the prior value, ready=1 on the next cycle.
REQ-036 Busy scenario: start pulsed with new operands during RUN -> ignored; only the original operation completes, with one done pulse.
